// File: rtl/spi_cmd_sequencer.sv
// SPI command sequencer: frames a 48-bit command, drives the serializer and hunts for the R1 response.
// Define SPI_CMD_CRC7_GEN_EN to compute CRC7 serially; otherwise a fixed CRC table is used.
module spi_cmd_sequencer #(
  parameter int RESP_TIMEOUT_BYTES = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sclk_posedge,
  input  logic        sclk_negedge,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [5:0]  cmd_index,
  input  logic [31:0] cmd_arg,
  input  logic        miso,
  output logic        cs_n,
  output logic        sender_en,
  output logic [47:0] sender_data,
  input  logic        sender_done,
  output logic        resp_valid,
  output logic [7:0]  resp_data,
  output logic        resp_timeout
);

  localparam int HUNT_MAX = RESP_TIMEOUT_BYTES * 8;
  localparam int HW       = $clog2(HUNT_MAX + 1);
  localparam logic [HW-1:0] HUNT_LAST = HW'(HUNT_MAX - 1);

`ifdef SPI_CMD_CRC7_GEN_EN
  typedef enum logic [2:0] {ST_IDLE, ST_CRC, ST_SEND, ST_WAIT, ST_RESP, ST_DONE} state_t;

  function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic din);
    logic fb;
    fb = din ^ crc[6];
    crc7_step = {crc[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
  endfunction
`else
  typedef enum logic [2:0] {ST_IDLE, ST_SEND, ST_WAIT, ST_RESP, ST_DONE} state_t;

  function automatic logic [6:0] crc7_fixed(input logic [5:0] idx);
    case (idx)
      6'd0:    crc7_fixed = 7'h4A;
      6'd8:    crc7_fixed = 7'h43;
      default: crc7_fixed = 7'h7F;
    endcase
  endfunction
`endif

  state_t          state_r, state_s;
  logic            cmd_ready_r, cmd_ready_s;
  logic            cs_n_r, cs_n_s;
  logic            sender_en_r, sender_en_s;
  logic [47:0]     sender_data_r, sender_data_s;
  logic            resp_valid_r, resp_valid_s;
  logic [7:0]      resp_data_r, resp_data_s;
  logic            resp_timeout_r, resp_timeout_s;
  logic [HW-1:0]   hunt_cnt_r, hunt_cnt_s;
  logic [2:0]      bit_cnt_r, bit_cnt_s;
  logic            found_r, found_s;
  logic [7:0]      shift_r, shift_s;
`ifdef SPI_CMD_CRC7_GEN_EN
  logic [5:0]      idx_r, idx_s;
  logic [31:0]     arg_r, arg_s;
  logic [6:0]      crc_r, crc_s;
  logic [5:0]      crc_cnt_r, crc_cnt_s;
  logic [39:0]     msg_s;
`endif
  logic            unused_s;

  assign unused_s = sclk_negedge;

  // Next-state and next-output computation; outputs are registered from these values.
  always_comb begin
    state_s        = state_r;
    cmd_ready_s    = cmd_ready_r;
    cs_n_s         = cs_n_r;
    sender_en_s    = 1'b0;
    sender_data_s  = sender_data_r;
    resp_valid_s   = 1'b0;
    resp_data_s    = resp_data_r;
    resp_timeout_s = resp_timeout_r;
    hunt_cnt_s     = hunt_cnt_r;
    bit_cnt_s      = bit_cnt_r;
    found_s        = found_r;
    shift_s        = shift_r;
`ifdef SPI_CMD_CRC7_GEN_EN
    idx_s          = idx_r;
    arg_s          = arg_r;
    crc_s          = crc_r;
    crc_cnt_s      = crc_cnt_r;
    msg_s          = {2'b01, idx_r, arg_r};
`endif
    case (state_r)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready_r) begin
          cmd_ready_s = 1'b0;
          cs_n_s      = 1'b0;
`ifdef SPI_CMD_CRC7_GEN_EN
          idx_s       = cmd_index;
          arg_s       = cmd_arg;
          crc_s       = 7'h00;
          crc_cnt_s   = 6'd0;
          state_s     = ST_CRC;
`else
          sender_en_s   = 1'b1;
          sender_data_s = {2'b01, cmd_index, cmd_arg, crc7_fixed(cmd_index), 1'b1};
          state_s       = ST_SEND;
`endif
        end else begin
          cmd_ready_s = 1'b1;
          cs_n_s      = 1'b1;
        end
      end
`ifdef SPI_CMD_CRC7_GEN_EN
      ST_CRC: begin
        // One message bit per clk, MSB first; the last step launches the frame directly.
        crc_s     = crc7_step(crc_r, msg_s[6'd39 - crc_cnt_r]);
        crc_cnt_s = crc_cnt_r + 6'd1;
        if (crc_cnt_r == 6'd39) begin
          sender_en_s   = 1'b1;
          sender_data_s = {2'b01, idx_r, arg_r, crc_s, 1'b1};
          state_s       = ST_SEND;
        end else begin
          state_s = ST_CRC;
        end
      end
`endif
      ST_SEND: begin
        state_s = ST_WAIT;
      end
      ST_WAIT: begin
        if (sender_done) begin
          hunt_cnt_s = '0;
          bit_cnt_s  = 3'd0;
          found_s    = 1'b0;
          shift_s    = 8'h00;
          state_s    = ST_RESP;
        end else begin
          state_s = ST_WAIT;
        end
      end
      ST_RESP: begin
        if (sclk_posedge) begin
          if (found_r) begin
            shift_s   = {shift_r[6:0], miso};
            bit_cnt_s = bit_cnt_r + 3'd1;
            if (bit_cnt_r == 3'd7) begin
              resp_data_s    = {shift_r[6:0], miso};
              resp_timeout_s = 1'b0;
              resp_valid_s   = 1'b1;
              cs_n_s         = 1'b1;
              state_s        = ST_DONE;
            end else begin
              state_s = ST_RESP;
            end
          end else if (!miso) begin
            // Start bit becomes bit 7; the zero already in shift_r walks up as bits arrive.
            found_s   = 1'b1;
            shift_s   = 8'h00;
            bit_cnt_s = 3'd1;
          end else if (hunt_cnt_r == HUNT_LAST) begin
            resp_data_s    = 8'hFF;
            resp_timeout_s = 1'b1;
            resp_valid_s   = 1'b1;
            cs_n_s         = 1'b1;
            state_s        = ST_DONE;
          end else begin
            hunt_cnt_s = hunt_cnt_r + HW'(1);
          end
        end else begin
          state_s = ST_RESP;
        end
      end
      ST_DONE: begin
        cmd_ready_s = 1'b1;
        cs_n_s      = 1'b1;
        state_s     = ST_IDLE;
      end
      default: begin
        cmd_ready_s = 1'b1;
        cs_n_s      = 1'b1;
        state_s     = ST_IDLE;
      end
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r        <= ST_IDLE;
      cmd_ready_r    <= 1'b1;
      cs_n_r         <= 1'b1;
      sender_en_r    <= 1'b0;
      sender_data_r  <= 48'hFFFF_FFFF_FFFF;
      resp_valid_r   <= 1'b0;
      resp_data_r    <= 8'hFF;
      resp_timeout_r <= 1'b0;
      hunt_cnt_r     <= '0;
      bit_cnt_r      <= 3'd0;
      found_r        <= 1'b0;
      shift_r        <= 8'h00;
`ifdef SPI_CMD_CRC7_GEN_EN
      idx_r          <= 6'd0;
      arg_r          <= 32'd0;
      crc_r          <= 7'h00;
      crc_cnt_r      <= 6'd0;
`endif
    end else begin
      state_r        <= state_s;
      cmd_ready_r    <= cmd_ready_s;
      cs_n_r         <= cs_n_s;
      sender_en_r    <= sender_en_s;
      sender_data_r  <= sender_data_s;
      resp_valid_r   <= resp_valid_s;
      resp_data_r    <= resp_data_s;
      resp_timeout_r <= resp_timeout_s;
      hunt_cnt_r     <= hunt_cnt_s;
      bit_cnt_r      <= bit_cnt_s;
      found_r        <= found_s;
      shift_r        <= shift_s;
`ifdef SPI_CMD_CRC7_GEN_EN
      idx_r          <= idx_s;
      arg_r          <= arg_s;
      crc_r          <= crc_s;
      crc_cnt_r      <= crc_cnt_s;
`endif
    end
  end

  assign cmd_ready    = cmd_ready_r;
  assign cs_n         = cs_n_r;
  assign sender_en    = sender_en_r;
  assign sender_data  = sender_data_r;
  assign resp_valid   = resp_valid_r;
  assign resp_data    = resp_data_r;
  assign resp_timeout = resp_timeout_r;

endmodule

// File: doc/spi_cmd_sequencer.md
SPI_CMD_SEQUENCER -- requirements
Module: spi_cmd_sequencer

Interface
REQ-001 Parameter: RESP_TIMEOUT_BYTES, default 8, the number of response bytes to hunt for an R1 start bit before declaring a timeout.
REQ-002 clk  in  1  system clock; all logic SHALL be synchronous to its rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 sclk_posedge, sclk_negedge  in  1 each  single-clk strobes marking SPI clock edges.
REQ-005 cmd_valid  in  1 / cmd_ready  out  1  command handshake; a command transfers when both are high on a clk edge.
REQ-006 cmd_index  in  6 / cmd_arg  in  32  command index and argument, captured at handshake.
REQ-007 miso  in  1  serial data from the card.
REQ-008 cs_n  out  1  active-low chip select.
REQ-009 sender_en  out  1 / sender_data  out  48 / sender_done  in  1  drive the 48-bit SPI serializer; sender_done is high when the serializer is idle and not enabled.
REQ-010 resp_valid  out  1 / resp_data  out  8 / resp_timeout  out  1  response result.

Function
REQ-011 States SHALL be IDLE, CRC, SEND, WAIT, RESP and DONE; all outputs SHALL be registered.
REQ-012 IDLE: cmd_ready=1 and cs_n=1; on handshake, latch index and argument, set cs_n=0 and go to CRC (macro defined) or SEND (macro undefined).
REQ-013 cmd_valid outside IDLE SHALL be ignored and cmd_ready SHALL be 0.
REQ-014 Frame SHALL be {2'b01, cmd_index, cmd_arg, crc7, 1'b1}, MSB first, placed on sender_data and held stable from SEND until the next handshake.
REQ-015 SEND: assert sender_en for exactly one clk, then go to WAIT.
REQ-016 WAIT: go to RESP on the first clk where sender_done=1; sender_en SHALL remain 0.
REQ-017 RESP: sample miso only on sclk_posedge strobes occurring strictly after RESP is entered.
- Before the start bit, shift nothing; the first sample equal to 0 SHALL be bit 7 of resp_data.
- Collect the next 7 samples as bits 6..0.
REQ-018 If RESP_TIMEOUT_BYTES*8 samples are taken without a 0 sample, set resp_data=8'hFF and resp_timeout=1, then go to DONE.
REQ-019 A start bit found on the final permitted sample SHALL complete normally, not time out.
REQ-020 DONE: resp_valid=1 for exactly one clk, cs_n=1, then return to IDLE. cmd_ready SHALL be 1 on the clk after resp_valid.
REQ-021 resp_data and resp_timeout SHALL hold their values until the next DONE.
REQ-022 Command latency with the macro undefined: handshake→sender_en = 1 clk. With the macro defined: 41 clks.

Reset
REQ-023 On reset, the block SHALL enter IDLE with the following values: cmd_ready=1, cs_n=1, sender_en=0, sender_data=48'hFFFF_FFFF_FFFF, resp_valid=0, resp_data=8'hFF, resp_timeout=0, and all counters cleared.
REQ-024 Reset asserted in any state, including mid-CRC, WAIT or RESP, SHALL take effect on that clk edge. No resp_valid SHALL be produced for the aborted command.

Configuration
REQ-025 Macro SPI_CMD_CRC7_GEN_EN.
- Defined: the CRC state SHALL compute CRC7 (polynomial x^7+x^3+1, initial value 0) serially over the 40 bits {2'b01, index, arg}, MSB first, one bit per clk, for 40 clks.
- Undefined: no CRC state; crc7 SHALL be 7'h4A when cmd_index=0, 7'h43 when cmd_index=8, and 7'h7F otherwise.

Verification
REQ-026 CMD0, arg 0; miso returns 0xFF, 0x01 → sender_data=48'h40_0000_0000_95, resp_data=8'h01, resp_timeout=0, resp_valid pulse of 1 clk.
REQ-027 CMD8, arg 0x000001AA (either macro setting) → sender_data=48'h48_0000_01AA_87; miso returns 0x01 at the 3rd byte → resp_data=8'h01.
REQ-028 miso held at 1; RESP_TIMEOUT_BYTES=8 → resp_valid after exactly 64 sampled posedges, with resp_data=8'hFF and resp_timeout=1.
REQ-029 Macro defined, CMD17, arg 0x00000000 → sender_data[7:0]=8'h55 (crc7=7'h2A), and sender_en occurs 41 clks after the handshake.
REQ-030 Reset pulse during RESP, then CMD0 issued → cs_n=1 and cmd_ready=1 on the clk after reset; no stale resp_valid; the second command completes normally.
